dadishu_game: RTL and testbench
===============================

# dadishu_game

Whack-a-mole game core for the 18-LED/18-switch board: lights one "mole" LED at a time, scores player hits on the matching slide switch, counts down a game timer, and drives seven active-low 7-segment digits (timer, score, speed level). It is the top-level game block fed directly by board pins on a 50 MHz clock.

## Interface
- CLK_HZ, 50_000_000, clock cycles per second (timer tick)
- GAME_SECONDS, 60, game length in seconds (≤ 99)
- MOLE_BASE_CYCLES, CLK_HZ/4, base mole-lifetime unit
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- speed1 / speed2 / speed3  in  1 each  active-low pushbuttons selecting speed level 1/2/3
- switches  in  18  slide switches; bit i hits hole i
- leds  out  18  one-hot mole position (all zero when no mole)
- seg_time_tens, seg_time_ones  out  7 each  remaining seconds
- seg_score_thou, seg_score_hund, seg_score_tens, seg_score_ones  out  7 each  BCD score
- seg_speed  out  7  speed digit 1–3
- All seg outputs: bit0=a … bit6=g, active-low (0 = lit).

## Operation
- Inputs: switches and buttons pass 2-flop synchronizers, then a registered rising-edge detect (switch 0→1; button 1→0).
- Speed: reset level 1; button falling edge sets level (speed1 has priority over 2 over 3 if simultaneous). Mole lifetime = 8 / 4 / 2 × MOLE_BASE_CYCLES for level 1/2/3; a change applies at next mole spawn.
- Mole position: 16-bit Fibonacci LFSR, seed 16'hACE1, taps 16,14,13,11, steps every clock. New index = LFSR mod 18; if equal to current index, use (index+1) mod 18.
- Spawn: on first cycle after reset release, on lifetime expiry (no score change), and on the cycle after a hit. Spawn reloads the lifetime counter.
- Hit: rising edge on switches[mole] → score +1 (BCD, saturates at 9999), mole cleared, respawn next cycle.
- Miss: any rising edge on a non-mole switch with no simultaneous hit → see Configuration. Hit takes priority over misses in the same cycle.
- Timer: BCD, loads GAME_SECONDS; decrements every CLK_HZ cycles. On reaching 00: game over — leds = 0, switch and speed inputs ignored, score frozen, until rst_n.

## Timing
- Reset values: leds=0; timer=GAME_SECONDS (displays "6","0"); score=0000; speed=1; LFSR=seed; game-over flag clear.
- Switch edge → score/leds update: 3 clocks (2 sync + 1 edge reg), then register update on that edge; seg outputs are combinational decode of registered values.
- Button → speed display: 3 clocks.
- Reset mid-game: immediate return to reset values.

## Configuration
- DADISHU_MISS_PENALTY_EN defined: a miss decrements score by 1, saturating at 0000.
- Undefined: misses ignored; score only increments.

## Structure
- Package dadishu_pkg: NUM_HOLES=18, LFSR seed/taps, lifetime multipliers 8/4/2, 7-segment digit encodings (0–9, blank).
- Sub-module seg7_decode (4-bit BCD → 7-bit active-low), instantiated seven times.

## Test plan
Use CLK_HZ=1000, MOLE_BASE_CYCLES=50.
- Reset → leds=0, timer segs "60", score "0000", speed "1"; one clock after release exactly one LED lit.
- switches = leds for 100 ns after 3+ clocks → score 0001, mole moves to different index.
- Penalty build: hit to 0001, then switches = ~leds → score 0000; second miss stays 0000. Non-penalty build: score unchanged.
- Pulse speed3 low → seg_speed shows 3; next mole lives 100 cycles at level 3 vs 400 at level 1 with no input.
- Run 60×CLK_HZ cycles → timer "00", leds=0, further hits leave score unchanged.
- Ten consecutive correct hits at level 3 → score 0010; assert rst_n low mid-game → all outputs at reset values.

Source files
------------

// File: rtl/dadishu_pkg.sv
// Shared constants, types and helpers for the whack-a-mole game core.
package dadishu_pkg;

  localparam int          NUM_HOLES = 18;
  localparam int          IDX_W     = 5;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int LIFE_MULT_L1 = 8;
  localparam int LIFE_MULT_L2 = 4;
  localparam int LIFE_MULT_L3 = 2;

  typedef enum logic [1:0] {
    SPEED_L1 = 2'd1,
    SPEED_L2 = 2'd2,
    SPEED_L3 = 2'd3
  } speed_e;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } game_state_e;

  // Active-low segment patterns, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  function automatic logic [6:0] seg7_encode(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = SEG_0;
      4'd1:    r = SEG_1;
      4'd2:    r = SEG_2;
      4'd3:    r = SEG_3;
      4'd4:    r = SEG_4;
      4'd5:    r = SEG_5;
      4'd6:    r = SEG_6;
      4'd7:    r = SEG_7;
      4'd8:    r = SEG_8;
      4'd9:    r = SEG_9;
      default: r = SEG_BLANK;
    endcase
    return r;
  endfunction

  // Four-digit BCD increment, holding at 9999.
  function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = (v != 16'h9999);
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          c = 1'b1;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        c = 1'b0;
      end
    end
    return r;
  endfunction

  // Four-digit BCD decrement, holding at 0000.
  function automatic logic [15:0] bcd4_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = (v != 16'h0000);
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
          b = 1'b1;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end else begin
        b = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to an active-low 7-segment pattern; non-decimal codes show blank.
module seg7_decode
  import dadishu_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  assign o_seg = seg7_encode(i_bcd);

endmodule

// File: rtl/dadishu_game.sv
// Whack-a-mole game core: mole spawning, hit scoring, countdown timer and display.
// Define DADISHU_MISS_PENALTY_EN to make a miss cost one point (saturating at 0000).
module dadishu_game
  import dadishu_pkg::*;
#(
  parameter int CLK_HZ           = 50_000_000,
  parameter int GAME_SECONDS     = 60,
  parameter int MOLE_BASE_CYCLES = CLK_HZ / 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 speed1,
  input  logic                 speed2,
  input  logic                 speed3,
  input  logic [NUM_HOLES-1:0] switches,
  output logic [NUM_HOLES-1:0] leds,
  output logic [6:0]           seg_time_tens,
  output logic [6:0]           seg_time_ones,
  output logic [6:0]           seg_score_thou,
  output logic [6:0]           seg_score_hund,
  output logic [6:0]           seg_score_tens,
  output logic [6:0]           seg_score_ones,
  output logic [6:0]           seg_speed
);

  localparam logic [31:0] TICK_LAST      = 32'(CLK_HZ - 1);
  localparam logic [31:0] LIFE_L1        = 32'(LIFE_MULT_L1 * MOLE_BASE_CYCLES - 1);
  localparam logic [31:0] LIFE_L2        = 32'(LIFE_MULT_L2 * MOLE_BASE_CYCLES - 1);
  localparam logic [31:0] LIFE_L3        = 32'(LIFE_MULT_L3 * MOLE_BASE_CYCLES - 1);
  localparam logic [3:0]  TIME_TENS_INIT = 4'(GAME_SECONDS / 10);
  localparam logic [3:0]  TIME_ONES_INIT = 4'(GAME_SECONDS % 10);

  logic [NUM_HOLES-1:0] r_sw_s1, r_sw_s2, r_sw_s3;
  logic [2:0]           r_btn_s1, r_btn_s2, r_btn_s3;
  logic [NUM_HOLES-1:0] w_sw_rise;
  logic [2:0]           w_btn_fall;

  speed_e               r_speed;
  logic [15:0]          r_lfsr;
  game_state_e          r_state;
  logic [NUM_HOLES-1:0] r_leds;
  logic [IDX_W-1:0]     r_mole_idx;
  logic [31:0]          r_life_cnt;
  logic                 r_respawn;
  logic [15:0]          r_score;
  logic [31:0]          r_tick_cnt;
  logic [3:0]           r_time_tens, r_time_ones;

  logic                 w_tick, w_time_end, w_hit, w_expire;
  logic [IDX_W-1:0]     w_rand_idx, w_next_idx;
  logic [NUM_HOLES-1:0] w_spawn_onehot;
  logic [31:0]          w_life_reload;
  logic [15:0]          w_score_next;
`ifdef DADISHU_MISS_PENALTY_EN
  logic                 w_miss;
`endif

  // Two-flop synchronizers plus one delay stage used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_sw_s3  <= '0;
      r_btn_s1 <= 3'b111;
      r_btn_s2 <= 3'b111;
      r_btn_s3 <= 3'b111;
    end else begin
      r_sw_s1  <= switches;
      r_sw_s2  <= r_sw_s1;
      r_sw_s3  <= r_sw_s2;
      r_btn_s1 <= {speed3, speed2, speed1};
      r_btn_s2 <= r_btn_s1;
      r_btn_s3 <= r_btn_s2;
    end
  end

  assign w_sw_rise  = r_sw_s2 & ~r_sw_s3;
  assign w_btn_fall = ~r_btn_s2 & r_btn_s3;

  // Speed level select; the lower-numbered button wins a tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_speed <= SPEED_L1;
    end else if (r_state == ST_OVER) begin
      r_speed <= r_speed;
    end else if (w_btn_fall[0]) begin
      r_speed <= SPEED_L1;
    end else if (w_btn_fall[1]) begin
      r_speed <= SPEED_L2;
    end else if (w_btn_fall[2]) begin
      r_speed <= SPEED_L3;
    end else begin
      r_speed <= r_speed;
    end
  end

  // Free-running position source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  // Countdown timer, frozen once the game is over
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt  <= '0;
      r_time_tens <= TIME_TENS_INIT;
      r_time_ones <= TIME_ONES_INIT;
    end else if (r_state == ST_OVER) begin
      r_tick_cnt <= r_tick_cnt;
    end else begin
      r_tick_cnt <= w_tick ? 32'd0 : r_tick_cnt + 32'd1;
      if (w_tick) begin
        if (r_time_ones == 4'd0) begin
          r_time_ones <= 4'd9;
          r_time_tens <= r_time_tens - 4'd1;
        end else begin
          r_time_ones <= r_time_ones - 4'd1;
        end
      end
    end
  end

  assign w_tick     = (r_tick_cnt == TICK_LAST);
  assign w_time_end = w_tick && (r_time_tens == 4'd0) && (r_time_ones == 4'd1);

  assign w_rand_idx     = IDX_W'(r_lfsr % 16'(NUM_HOLES));
  assign w_next_idx     = (w_rand_idx != r_mole_idx) ? w_rand_idx :
                          (r_mole_idx == IDX_W'(NUM_HOLES - 1)) ? IDX_W'(0) :
                          r_mole_idx + IDX_W'(1);
  assign w_spawn_onehot = {{(NUM_HOLES-1){1'b0}}, 1'b1} << w_next_idx;

  assign w_hit    = |(w_sw_rise & r_leds);
  assign w_expire = (r_leds != '0) && (r_life_cnt == 32'd0);
`ifdef DADISHU_MISS_PENALTY_EN
  assign w_miss   = |(w_sw_rise & ~r_leds);
`endif

  // Mole lifetime reload for the current speed level
  always_comb begin
    w_life_reload = LIFE_L1;
    case (r_speed)
      SPEED_L1: w_life_reload = LIFE_L1;
      SPEED_L2: w_life_reload = LIFE_L2;
      SPEED_L3: w_life_reload = LIFE_L3;
      default:  w_life_reload = LIFE_L1;
    endcase
  end

  // Score update: a hit outranks any misses in the same cycle
  always_comb begin
    w_score_next = r_score;
    if (w_hit) begin
      w_score_next = bcd4_inc(r_score);
`ifdef DADISHU_MISS_PENALTY_EN
    end else if (w_miss) begin
      w_score_next = bcd4_dec(r_score);
`endif
    end else begin
      w_score_next = r_score;
    end
  end

  // Game FSM: spawn, hit, expiry and game-over handling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_START;
      r_leds     <= '0;
      r_mole_idx <= '0;
      r_life_cnt <= '0;
      r_respawn  <= 1'b0;
      r_score    <= '0;
    end else begin
      case (r_state)
        ST_START: begin
          r_leds     <= w_spawn_onehot;
          r_mole_idx <= w_next_idx;
          r_life_cnt <= w_life_reload;
          r_respawn  <= 1'b0;
          r_state    <= ST_PLAY;
        end
        ST_PLAY: begin
          if (w_time_end) begin
            r_state   <= ST_OVER;
            r_leds    <= '0;
            r_respawn <= 1'b0;
          end else begin
            r_score <= w_score_next;
            if (w_hit) begin
              r_leds    <= '0;
              r_respawn <= 1'b1;
            end else if (r_respawn || w_expire) begin
              r_leds     <= w_spawn_onehot;
              r_mole_idx <= w_next_idx;
              r_life_cnt <= w_life_reload;
              r_respawn  <= 1'b0;
            end else if (r_life_cnt != 32'd0) begin
              r_life_cnt <= r_life_cnt - 32'd1;
            end
          end
        end
        ST_OVER: begin
          r_leds <= '0;
        end
        default: begin
          r_state <= ST_START;
          r_leds  <= '0;
        end
      endcase
    end
  end

  assign leds = r_leds;

  seg7_decode u_seg_time_tens  (.i_bcd(r_time_tens),       .o_seg(seg_time_tens));
  seg7_decode u_seg_time_ones  (.i_bcd(r_time_ones),       .o_seg(seg_time_ones));
  seg7_decode u_seg_score_thou (.i_bcd(r_score[15:12]),    .o_seg(seg_score_thou));
  seg7_decode u_seg_score_hund (.i_bcd(r_score[11:8]),     .o_seg(seg_score_hund));
  seg7_decode u_seg_score_tens (.i_bcd(r_score[7:4]),      .o_seg(seg_score_tens));
  seg7_decode u_seg_score_ones (.i_bcd(r_score[3:0]),      .o_seg(seg_score_ones));
  seg7_decode u_seg_speed      (.i_bcd({2'b00, r_speed}),  .o_seg(seg_speed));

endmodule

// File: tb/tb_dadishu_game.sv
// Self-checking bench for dadishu_game with randomized hit/miss timing and a score/speed model.
`timescale 1ns/1ps
module tb_dadishu_game;

  localparam int CLK_HZ       = 1000;
  localparam int GAME_SECONDS = 60;
  localparam int MOLE_BASE    = 50;
  localparam int SEED         = 16'hACE1;

  logic        clk, rst_n, speed1, speed2, speed3;
  logic [17:0] switches, leds;
  logic [6:0]  seg_time_tens, seg_time_ones;
  logic [6:0]  seg_score_thou, seg_score_hund, seg_score_tens, seg_score_ones;
  logic [6:0]  seg_speed;

  int n_checks, n_errors;
  int exp_score, exp_speed;
  int cyc;

  dadishu_game #(
    .CLK_HZ(CLK_HZ), .GAME_SECONDS(GAME_SECONDS), .MOLE_BASE_CYCLES(MOLE_BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .speed1(speed1), .speed2(speed2), .speed3(speed3),
    .switches(switches), .leds(leds),
    .seg_time_tens(seg_time_tens), .seg_time_ones(seg_time_ones),
    .seg_score_thou(seg_score_thou), .seg_score_hund(seg_score_hund),
    .seg_score_tens(seg_score_tens), .seg_score_ones(seg_score_ones),
    .seg_speed(seg_speed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Active-high gfedcba patterns inverted to the board's active-low drive.
  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] on;
    case (d)
      0: on = 7'b0111111;
      1: on = 7'b0000110;
      2: on = 7'b1011011;
      3: on = 7'b1001111;
      4: on = 7'b1100110;
      5: on = 7'b1101101;
      6: on = 7'b1111101;
      7: on = 7'b0000111;
      8: on = 7'b1111111;
      9: on = 7'b1101111;
      default: on = 7'b0000000;
    endcase
    return ~on;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_score(input string tag);
    check_eq(tag, 32'({seg_score_thou, seg_score_hund, seg_score_tens, seg_score_ones}),
             32'({seg_of(exp_score / 1000), seg_of((exp_score / 100) % 10),
                  seg_of((exp_score / 10) % 10), seg_of(exp_score % 10)}));
  endtask

  task automatic check_timer(input string tag, input int secs);
    check_eq(tag, 32'({seg_time_tens, seg_time_ones}),
             32'({seg_of(secs / 10), seg_of(secs % 10)}));
  endtask

  task automatic check_speed(input string tag);
    check_eq(tag, 32'(seg_speed), 32'(seg_of(exp_speed)));
  endtask

  task automatic wait_spawn(input string tag);
    logic [17:0] prev;
    int n;
    prev = leds;
    n = 0;
    while ((leds == prev || leds == 18'd0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic measure_life(input string tag, input int exp_cycles);
    logic [17:0] prev;
    int n;
    wait_spawn(tag);
    prev = leds;
    n = 0;
    while (leds == prev && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(n), 32'(exp_cycles));
  endtask

  task automatic do_hit(input string tag);
    logic [17:0] old;
    old = leds;
    switches = leds;
    tick(6);
    if (exp_score < 9999) exp_score++;
    check_eq({tag, "_move"}, 32'((leds != old) && $onehot(leds)), 32'd1);
    switches = 18'd0;
    tick(3);
    check_score(tag);
  endtask

  task automatic do_miss(input string tag, input bit all_holes);
    logic [17:0] m;
    if (all_holes) m = ~leds;
    else           m = 18'($urandom()) & ~leds;
    if (m == 18'd0) m = ~leds;
    switches = m;
    tick(5);
    switches = 18'd0;
    tick(3);
`ifdef DADISHU_MISS_PENALTY_EN
    if (exp_score > 0) exp_score--;
`endif
    check_score(tag);
  endtask

  task automatic release_and_check_first(input string tag);
    logic [17:0] first_exp;
    first_exp = 18'd1 << (SEED % 18);
    rst_n = 1'b1;
    tick(1);
    check_eq(tag, 32'(leds), 32'(first_exp));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    exp_score = 0; exp_speed = 1;
    rst_n = 1'b0; speed1 = 1'b1; speed2 = 1'b1; speed3 = 1'b1;
    switches = 18'd0;
    tick(3);

    check_eq("rst_leds", 32'(leds), 32'd0);
    check_timer("rst_timer", GAME_SECONDS);
    check_score("rst_score");
    check_speed("rst_speed");
    release_and_check_first("first_mole");

    measure_life("life_l1", 8 * MOLE_BASE);

    tick($urandom_range(0, 40));
    do_hit("hit1");
    do_miss("miss_all", 1'b1);
    do_miss("miss_rand", 1'b0);

    speed3 = 1'b0;
    tick(2);
    speed3 = 1'b1;
    tick(2);
    exp_speed = 3;
    check_speed("speed3");
    measure_life("life_l3", 2 * MOLE_BASE);

    for (int i = 0; i < 10; i++) begin
      tick($urandom_range(0, 40));
      do_hit("hit_l3");
    end
    check_score("ten_hits");

    tick($urandom_range(5, 30));
    #2;
    rst_n = 1'b0;
    exp_score = 0; exp_speed = 1;
    #1;
    check_eq("midrst_leds", 32'(leds), 32'd0);
    check_timer("midrst_timer", GAME_SECONDS);
    check_score("midrst_score");
    check_speed("midrst_speed");
    @(negedge clk);
    tick(2);
    release_and_check_first("first_mole2");

    for (int i = 0; i < 3; i++) begin
      tick($urandom_range(0, 40));
      do_hit("hit_game");
    end

    while (cyc < CLK_HZ - 1) tick(1);
    check_timer("timer_before_1s", GAME_SECONDS);
    tick(1);
    check_timer("timer_after_1s", GAME_SECONDS - 1);

    while (cyc < GAME_SECONDS * CLK_HZ - 1) tick(1);
    check_timer("timer_01", 1);
    tick(1);
    check_timer("timer_00", 0);
    tick(1);
    check_eq("over_leds", 32'(leds), 32'd0);

    for (int i = 0; i < 3; i++) begin
      switches = 18'($urandom()) | 18'd1;
      tick(5);
      switches = 18'd0;
      tick(3);
    end
    speed2 = 1'b0;
    tick(3);
    speed2 = 1'b1;
    tick(4);
    check_score("over_score_frozen");
    check_speed("over_speed_frozen");
    check_eq("over_leds_still", 32'(leds), 32'd0);
    check_timer("over_timer_held", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
